upcounter_mod: RTL and testbench
================================

Name: upcounter_mod

Overview:
- Modulo-N up counter: counts up from 0 to MAX_VAL under a count-enable.
- Supports synchronous parallel load (clamped to MAX_VAL), a terminal-count flag, a one-cycle carry pulse for cascading, and a one-shot mode that halts at MAX_VAL.
- Sits alongside the down-counter in the counter/timer library. It is the up-direction counterpart used for event counting, decade digits and prescalers.

Parameters:
- WIDTH, 4, counter width in bits.
- MAX_VAL, 15, terminal value. Legal range 1..2^WIDTH-1. Counting wraps from MAX_VAL to 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- up  input  1  count enable; increment request, sampled each rising edge.
- load  input  1  synchronous load strobe; takes priority over up.
- d  input  WIDTH  load value.
- oneshot  input  1  mode select. 0 = free-running wrap, 1 = halt at MAX_VAL.
- q  output  WIDTH  counter value, registered.
- tc  output  1  terminal count. Combinational: tc = (q == MAX_VAL).
- carry  output  1  registered one-cycle pulse; asserted when an increment is requested at MAX_VAL.
- done  output  1  registered; high while the one-shot halt state is held.

Behaviour:
- Reset (rst low, asynchronous):
  - q=0, carry=0, done=0, state=RUN.
  - tc is 0, since q=0 and MAX_VAL≥1.
  - Release is synchronous in effect: the first update occurs on the first rising edge with rst high.
- States: RUN and HALT. done is 1 exactly when state is HALT.
- RUN, evaluated per rising edge in this priority order:
  1. load=1: q <= min(d, MAX_VAL); carry <= 0; stay in RUN.
  2. up=1, q==MAX_VAL, oneshot=0: q <= 0; carry <= 1.
  3. up=1, q==MAX_VAL, oneshot=1: q holds MAX_VAL; carry <= 1; state <= HALT; done <= 1.
  4. up=1, q<MAX_VAL: q <= q+1; carry <= 0.
  5. otherwise: q holds; carry <= 0.
- HALT, per rising edge:
  - load=1: q <= min(d, MAX_VAL); state <= RUN; done <= 0; carry <= 0.
  - up=1 and oneshot=0: q <= 0; state <= RUN; done <= 0; carry <= 0.
  - otherwise: q holds MAX_VAL; done stays 1; carry <= 0.
  - up=1 with oneshot=1 is ignored and produces no further carry pulses.
- Latency:
  - q, carry and done change one edge after the qualifying inputs are sampled.
  - tc follows q combinationally, in the same cycle as q.
- Carry pulse width is exactly one cycle per qualifying increment. With up held continuously at MAX_VAL in free-run mode, carry pulses once per wrap.
- Load clamp: if d > MAX_VAL, q loads MAX_VAL. No out-of-range value is ever presented on q.
- Mode change: oneshot is sampled every edge and has no state of its own. Switching it mid-count changes behaviour only at the next MAX_VAL event.
- Simultaneous load and up: load wins; the increment is discarded.
- Reset mid-count or in HALT: immediate return to the reset values, regardless of clk.
- Arithmetic: increment is modulo MAX_VAL+1. Internal sums are WIDTH bits; no overflow beyond MAX_VAL is possible.

Test Plan:
- Reset/count (WIDTH=4, MAX_VAL=9): hold rst low 3 cycles → q=0, carry=0, done=0. Release and hold up=1 for 10 edges → q steps 1..9 then 0. carry=1 only in the cycle after q=9 is sampled with up=1. tc=1 only while q=9.
- Load clamp/priority: load=1, d=4'd13, up=1 → q=9 next cycle, carry=0. Then load=1, d=3, up=1 → q=3, not 4.
- Enable gating: up toggles 1,0,1,0 from q=0 → q=1,1,2,2. No carry.
- One-shot halt: oneshot=1, load 8, then up=1 for 5 edges → q=9, then HALT with q=9, done=1. A single carry pulse; q and done stay put on further edges. Then drop oneshot with up=1 → q=0, done=0 next cycle.
- HALT exit by load: in HALT, load=1, d=2 → q=2, done=0, state RUN. Counting resumes on up.
- Async reset mid-operation: at q=6 (or in HALT), pulse rst low between clock edges → q=0, done=0, carry=0 immediately, before the next edge.

Source files
------------

// File: rtl/upcounter_mod.sv
// Modulo-(MAX_VAL+1) up counter with synchronous clamped load, terminal-count
// flag, one-cycle cascade carry and an optional one-shot halt at MAX_VAL.
module upcounter_mod #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active low
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry,
  output logic             done
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] load_val;
  logic             at_max;

  // Load value clamped so q never shows anything above MAX_VAL.
  always_comb begin
    load_val = (d > MaxVal) ? MaxVal : d;
    at_max   = (cnt_q == MaxVal);
  end

  // Next-state: load beats increment; carry is only ever a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (load) begin
          cnt_d = load_val;
        end else if (up && at_max) begin
          carry_d = 1'b1;
          if (oneshot) begin
            state_d = StHalt;
          end else begin
            cnt_d = '0;
          end
        end else if (up) begin
          cnt_d = cnt_q + One;
        end
      end
      StHalt: begin
        // up with oneshot still set is ignored: no further carries.
        if (load) begin
          cnt_d   = load_val;
          state_d = StRun;
        end else if (up && !oneshot) begin
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // Outputs: done comes straight from the state flop, tc follows q.
  always_comb begin
    q     = cnt_q;
    tc    = at_max;
    carry = carry_q;
    done  = (state_q == StHalt);
  end

endmodule

// File: tb/tb_upcounter_mod.sv
// Directed self-checking bench for upcounter_mod at WIDTH=4, MAX_VAL=9.
module tb_upcounter_mod;

  logic       clk;
  logic       rst;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic       oneshot;
  logic [3:0] q;
  logic       tc;
  logic       carry;
  logic       done;

  int total = 0;
  int bad   = 0;

  upcounter_mod #(
    .WIDTH  (4),
    .MAX_VAL(9)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .up     (up),
    .load   (load),
    .d      (d),
    .oneshot(oneshot),
    .q      (q),
    .tc     (tc),
    .carry  (carry),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic ec,
                         input logic ed, input logic et);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".carry"}, 32'(carry), 32'(ec));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".tc"}, 32'(tc), 32'(et));
  endtask

  initial begin
    rst = 1'b0; up = 1'b0; load = 1'b0; d = 4'd0; oneshot = 1'b0;

    // Reset held for three edges
    tick(); tick(); tick();
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // Free-running count 1..9 then wrap with one carry
    rst = 1'b1; up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_all("count", 4'(i % 10), (i == 10), 1'b0, (i == 9));
    end

    // Load clamp and load-over-up priority
    load = 1'b1; d = 4'd13; up = 1'b1;
    tick();
    chk_all("clamp", 4'd9, 1'b0, 1'b0, 1'b1);
    d = 4'd3;
    tick();
    chk_all("ldprio", 4'd3, 1'b0, 1'b0, 1'b0);

    // Enable gating from zero
    d = 4'd0; up = 1'b0;
    tick();
    chk("ld0.q", 32'(q), 32'd0);
    load = 1'b0;
    up = 1'b1; tick(); chk_all("gate1", 4'd1, 1'b0, 1'b0, 1'b0);
    up = 1'b0; tick(); chk_all("gate2", 4'd1, 1'b0, 1'b0, 1'b0);
    up = 1'b1; tick(); chk_all("gate3", 4'd2, 1'b0, 1'b0, 1'b0);
    up = 1'b0; tick(); chk_all("gate4", 4'd2, 1'b0, 1'b0, 1'b0);

    // One-shot: load 8, count to 9, halt with exactly one carry
    oneshot = 1'b1; load = 1'b1; d = 4'd8;
    tick();
    chk("os_ld.q", 32'(q), 32'd8);
    load = 1'b0; up = 1'b1;
    tick(); chk_all("os1", 4'd9, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("os2", 4'd9, 1'b1, 1'b1, 1'b1);
    tick(); chk_all("os3", 4'd9, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("os4", 4'd9, 1'b0, 1'b1, 1'b1);
    tick(); chk_all("os5", 4'd9, 1'b0, 1'b1, 1'b1);
    oneshot = 1'b0;
    tick(); chk_all("os_exit", 4'd0, 1'b0, 1'b0, 1'b0);

    // HALT exit by load, then counting resumes
    oneshot = 1'b1; load = 1'b1; d = 4'd9; up = 1'b0;
    tick();
    load = 1'b0; up = 1'b1;
    tick(); chk_all("halt_in", 4'd9, 1'b1, 1'b1, 1'b1);
    load = 1'b1; d = 4'd2;
    tick(); chk_all("halt_ld", 4'd2, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    tick(); chk_all("resume", 4'd3, 1'b0, 1'b0, 1'b0);
    oneshot = 1'b0;

    // Asynchronous reset mid-count at q=6
    load = 1'b1; d = 4'd6; up = 1'b0;
    tick();
    chk("pre_rst.q", 32'(q), 32'd6);
    load = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all("arst_run", 4'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in HALT while carry is high
    rst = 1'b1; oneshot = 1'b1; load = 1'b1; d = 4'd9;
    tick();
    load = 1'b0; up = 1'b1;
    tick(); chk_all("pre_arst", 4'd9, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 chk_all("arst_halt", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("arst_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; oneshot = 1'b0;
    tick(); chk_all("post_rst", 4'd1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
